alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter RING_TIMEOUT, default 60, seconds of ringing before auto-stop; legal range 1..511.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, seconds of silence per snooze; legal range 1..511.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event; legal range 0..3.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port arm  input  1  level; 1 = alarm enabled, 0 = alarm disabled.
REQ-007 SHALL have port match  input  1  level; current time equals alarm time (clk-synchronous).
REQ-008 SHALL have port tick_1hz  input  1  single-cycle pulse once per second, clk domain.
REQ-009 SHALL have port stop_key  input  1  single-cycle pulse from keyboard key controller.
REQ-010 SHALL have port snooze_key  input  1  single-cycle pulse from keyboard key controller.
REQ-011 SHALL have port play_sound  output  1  registered; drives song player playSound.
REQ-012 SHALL have port state  output  2  registered; IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-013 SHALL have port snooze_cnt  output  2  registered; snoozes used in current alarm event.

Function
REQ-014 SHALL detect match rising edge using a registered copy match_q, updated every cycle in every state.
REQ-015 IDLE: SHALL go to ARMED when arm=1.
REQ-016 ARMED: SHALL go to RINGING on the cycle match=1 and match_q=0; a match already high at arm assertion SHALL NOT ring.
REQ-017 arm=0 SHALL force IDLE from any state next edge, clearing counters and snooze_cnt; highest priority after reset.
REQ-018 RINGING: stop_key SHALL go to ARMED, clearing snooze_cnt.
REQ-019 RINGING: snooze_key with snooze_cnt < MAX_SNOOZE SHALL go to SNOOZE and increment snooze_cnt; otherwise snooze_key ignored.
REQ-020 RINGING: 9-bit second counter cleared on entry, incremented per tick_1hz; tick arriving with counter = RING_TIMEOUT-1 SHALL go to ARMED, clearing snooze_cnt.
REQ-021 SNOOZE: 9-bit counter cleared on entry; tick arriving with counter = SNOOZE_SECS-1 SHALL go to RINGING; stop_key SHALL go to ARMED, clearing snooze_cnt.
REQ-022 Match edges during RINGING or SNOOZE SHALL be ignored.
REQ-023 Same-cycle priority: arm=0 > stop_key > snooze_key > tick expiry.
REQ-024 play_sound SHALL equal 1 exactly while state=RINGING, updated on the same edge as state; latency match edge to play_sound=1 is one clk.
REQ-025 Counters SHALL never wrap; they hold at terminal value only transiently since expiry leaves the state.

Reset
REQ-026 reset=0 SHALL asynchronously set state=IDLE, play_sound=0, snooze_cnt=0, counters=0, match_q=1.
REQ-027 Reset release mid-ringing SHALL NOT resume ringing; block restarts from IDLE.

Configuration
REQ-028 Macro ALARM_SEQUENCER_SNOOZE_EN defined: snooze behaviour per REQ-019/021.
REQ-029 Macro undefined: snooze_key ignored, SNOOZE unreachable, snooze_cnt tied 0, SNOOZE_SECS unused; all other behaviour identical.

Verification (bench params RING_TIMEOUT=5, SNOOZE_SECS=3, MAX_SNOOZE=2, snooze enabled)
REQ-030 arm=1, match 0->1 -> state=2, play_sound=1 one clk later; no keys, 5 ticks -> state=1, play_sound=0 after 5th tick.
REQ-031 Ringing, snooze_key -> state=3, snooze_cnt=1, play_sound=0; 3 ticks -> state=2, play_sound=1.
REQ-032 Snooze twice, ringing again, snooze_key -> ignored, state stays 2, snooze_cnt=2; stop_key -> state=1, snooze_cnt=0.
REQ-033 stop_key and snooze_key same cycle while ringing -> state=1; match held high then arm toggled 0->1 -> no ring.
REQ-034 reset=0 asserted mid-ringing between edges -> play_sound=0 immediately, state=0; macro undefined build: snooze_key while ringing -> state stays 2.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms, rings on match rising edge, auto-stops, optional snooze.
// Optional snooze feature enabled by defining ALARM_SEQUENCER_SNOOZE_EN.
module alarm_sequencer #(
    parameter int unsigned RING_TIMEOUT = 60,
    parameter int unsigned SNOOZE_SECS  = 300,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       match,
    input  logic       tick_1hz,
    input  logic       stop_key,
    input  logic       snooze_key,
    output logic       play_sound,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_TIMEOUT - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);

`ifdef ALARM_SEQUENCER_SNOOZE_EN
    localparam bit SNOOZE_EN = 1'b1;
`else
    localparam bit SNOOZE_EN = 1'b0;
`endif

    state_t     r_state;
    state_t     w_next_state;
    logic [8:0] r_sec_cnt;
    logic [8:0] w_next_sec_cnt;
    logic [1:0] r_snooze_cnt;
    logic [1:0] w_next_snooze_cnt;
    logic       r_match_q;
    logic       r_play;
    logic       w_match_rise;
    logic       w_snooze_ok;

    assign w_match_rise = match & ~r_match_q;
    // With the feature disabled this folds to 0, so SNOOZE can never be entered.
    assign w_snooze_ok  = SNOOZE_EN && snooze_key && (32'(r_snooze_cnt) < MAX_SNOOZE);

    always_comb begin
        w_next_state      = r_state;
        w_next_sec_cnt    = r_sec_cnt;
        w_next_snooze_cnt = r_snooze_cnt;
        if (!arm) begin
            w_next_state      = IDLE;
            w_next_sec_cnt    = '0;
            w_next_snooze_cnt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state      = ARMED;
                    w_next_sec_cnt    = '0;
                    w_next_snooze_cnt = '0;
                end
                ARMED: begin
                    w_next_sec_cnt = '0;
                    if (w_match_rise) begin
                        w_next_state = RINGING;
                    end
                end
                RINGING: begin
                    if (stop_key) begin
                        w_next_state      = ARMED;
                        w_next_sec_cnt    = '0;
                        w_next_snooze_cnt = '0;
                    end else if (w_snooze_ok) begin
                        w_next_state      = SNOOZE;
                        w_next_sec_cnt    = '0;
                        w_next_snooze_cnt = r_snooze_cnt + 2'd1;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == RING_LAST) begin
                            w_next_state      = ARMED;
                            w_next_sec_cnt    = '0;
                            w_next_snooze_cnt = '0;
                        end else begin
                            w_next_sec_cnt = r_sec_cnt + 9'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_key) begin
                        w_next_state      = ARMED;
                        w_next_sec_cnt    = '0;
                        w_next_snooze_cnt = '0;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == SNOOZE_LAST) begin
                            w_next_state   = RINGING;
                            w_next_sec_cnt = '0;
                        end else begin
                            w_next_sec_cnt = r_sec_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    w_next_state      = IDLE;
                    w_next_sec_cnt    = '0;
                    w_next_snooze_cnt = '0;
                end
            endcase
        end
    end

    // match_q resets high so a match already asserted at reset release never rings.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sec_cnt    <= '0;
            r_snooze_cnt <= '0;
            r_match_q    <= 1'b1;
            r_play       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sec_cnt    <= w_next_sec_cnt;
            r_snooze_cnt <= w_next_snooze_cnt;
            r_match_q    <= match;
            r_play       <= (w_next_state == RINGING);
        end
    end

    assign state      = r_state;
    assign play_sound = r_play;
    assign snooze_cnt = SNOOZE_EN ? r_snooze_cnt : 2'b00;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios then random traffic against a
// countdown-based reference model; adapts to ALARM_SEQUENCER_SNOOZE_EN.
module tb_alarm_sequencer;

    localparam int RT  = 5;
    localparam int SS  = 3;
    localparam int MAX = 2;
`ifdef ALARM_SEQUENCER_SNOOZE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm = 1'b0;
    logic       match = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       stop_key = 1'b0;
    logic       snooze_key = 1'b0;
    logic       play_sound;
    logic [1:0] state;
    logic [1:0] snooze_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0..3 as the visible state, 'left' counts seconds
    // remaining in the current ring/snooze period, 'used' counts snoozes taken.
    int m_mode;
    int m_left;
    int m_used;
    bit m_prev_match;
    string tag;

    alarm_sequencer #(
        .RING_TIMEOUT(RT),
        .SNOOZE_SECS (SS),
        .MAX_SNOOZE  (MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .match     (match),
        .tick_1hz  (tick_1hz),
        .stop_key  (stop_key),
        .snooze_key(snooze_key),
        .play_sound(play_sound),
        .state     (state),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_used = 0;
        m_prev_match = 1'b1;
    endtask

    task automatic model_clock();
        bit rise;
        if (!reset) begin
            model_reset();
            return;
        end
        rise = match && !m_prev_match;
        m_prev_match = match;
        if (!arm) begin
            m_mode = 0;
            m_used = 0;
            m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rise) begin
                m_mode = 2;
                m_left = RT;
            end
        end else if (m_mode == 2) begin
            if (stop_key) begin
                m_mode = 1;
                m_used = 0;
            end else if (EN && snooze_key && m_used < MAX) begin
                m_mode = 3;
                m_used++;
                m_left = SS;
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 1;
                    m_used = 0;
                end
            end
        end else begin
            if (stop_key) begin
                m_mode = 1;
                m_used = 0;
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = RT;
                end
            end
        end
    endtask

    task automatic check_all();
        chk({tag, ".state"}, state, 2'(m_mode));
        chk({tag, ".play"}, {1'b0, play_sound}, (m_mode == 2) ? 2'd1 : 2'd0);
        chk({tag, ".snz"}, snooze_cnt, EN ? 2'(m_used) : 2'd0);
    endtask

    task automatic step(input logic a, input logic m, input logic t,
                        input logic st, input logic sz);
        arm = a;
        match = m;
        tick_1hz = t;
        stop_key = st;
        snooze_key = sz;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1'b1, m, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n, input logic m);
        for (int i = 0; i < n; i++) begin
            step(1'b1, m, 1'b1, 1'b0, 1'b0);
            step(1'b1, m, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic rm;
        model_reset();
        #3;
        tag = "reset";
        chk("reset.state", state, 2'd0);
        chk("reset.play", {1'b0, play_sound}, 2'd0);
        chk("reset.snz", snooze_cnt, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        tag = "arm";
        idle_steps(3, 1'b0);
        tag = "ring_entry";
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ring_entry.const", state, 2'd2);
        tag = "auto_stop";
        ticks(RT, 1'b1);
        chk("auto_stop.const", state, 2'd1);

        tag = "snooze_seq";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(SS, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(SS, 1'b1);
        tag = "snooze_limit";
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_steps(2, 1'b1);
        tag = "stop";
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        tag = "stop_and_snooze";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tag = "rearm_match_high";
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_steps(4, 1'b1);

        tag = "async_reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset.play", {1'b0, play_sound}, 2'd0);
        chk("async_reset.state", state, 2'd0);
        model_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tag = "after_reset";
        idle_steps(4, 1'b1);

        tag = "random";
        rm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rm = ~rm;
            step(($urandom_range(0, 39) != 0), rm, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 14) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
